// File: rtl/async_ram_pkg.sv
// async_ram_pkg: shared constants and word type for the 8 x 16 dual-port RAM.
//   RAM_DATA_W : data word width in bits
//   RAM_ADDR_W : address width in bits
//   RAM_DEPTH  : number of words (2**RAM_ADDR_W)
//   ram_word_t : one stored data word
package async_ram_pkg;

  localparam int unsigned RAM_DATA_W = 16;
  localparam int unsigned RAM_ADDR_W = 3;
  localparam int unsigned RAM_DEPTH  = 8;

  typedef logic [RAM_DATA_W-1:0] ram_word_t;

endpackage : async_ram_pkg

// File: rtl/async_ram_if.sv
// async_ram_if: write/read port bundle of the dual-port RAM.
//   we       : write enable
//   re       : read enable
//   data_in  : write data
//   wr_addr  : write address
//   rd_addr  : read address
//   data_out : registered read data
// master modport drives the request side; slave modport is the RAM side.
interface async_ram_if
  import async_ram_pkg::*;
#(
  parameter int unsigned DATA_W = RAM_DATA_W,
  parameter int unsigned ADDR_W = RAM_ADDR_W
) ();

  logic              we;
  logic              re;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] data_out;

  modport master (
    output we, re, data_in, wr_addr, rd_addr,
    input  data_out
  );

  modport slave (
    input  we, re, data_in, wr_addr, rd_addr,
    output data_out
  );

endinterface : async_ram_if

// File: rtl/async_ram_array.sv
// async_ram_array: storage array with synchronous write port and
// asynchronous clear.
//   clk_i     : clock, write on rising edge
//   clr_i     : asynchronous active-high clear of every word
//   we_i      : write enable
//   wr_addr_i : write address
//   data_i    : write data
//   rd_addr_i : read address
//   rd_data_o : combinational view of the currently stored word at rd_addr_i
module async_ram_array
  import async_ram_pkg::*;
#(
  parameter int unsigned DATA_W = RAM_DATA_W,
  parameter int unsigned ADDR_W = RAM_ADDR_W,
  parameter int unsigned DEPTH  = RAM_DEPTH
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we_i) mem_d[wr_addr_i] = data_i;
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read from the registered array: a same-edge write to this address is
  // not yet visible, which gives read-before-write on collisions.
  assign rd_data_o = mem_q[rd_addr_i];

endmodule : async_ram_array

// File: rtl/async_ram.sv
// async_ram: 8 x 16 simple dual-port RAM, single clock, registered read.
//   clk : clock, all accesses on its rising edge
//   clr : asynchronous active-high clear of array and data_out
//   bus : slave side of async_ram_if (we, re, data_in, wr_addr, rd_addr,
//         data_out); data_out holds its value while re is low
module async_ram
  import async_ram_pkg::*;
#(
  parameter int unsigned DATA_W = RAM_DATA_W,
  parameter int unsigned ADDR_W = RAM_ADDR_W,
  parameter int unsigned DEPTH  = RAM_DEPTH
) (
  input  logic        clk,
  input  logic        clr,
  async_ram_if.slave  bus
);

  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] data_out_q;
  logic [DATA_W-1:0] data_out_d;

  async_ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i     (clk),
    .clr_i     (clr),
    .we_i      (bus.we),
    .wr_addr_i (bus.wr_addr),
    .data_i    (bus.data_in),
    .rd_addr_i (bus.rd_addr),
    .rd_data_o (rd_word)
  );

  always_comb begin
    data_out_d = data_out_q;
    if (bus.re) data_out_d = rd_word;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) data_out_q <= '0;
    else     data_out_q <= data_out_d;
  end

  assign bus.data_out = data_out_q;

endmodule : async_ram

// File: tb/tb_async_ram.sv
// tb_async_ram: self-checking bench for async_ram against a behavioural
// array model (read sees old contents, then write applies; clear zeroes all).
module tb_async_ram;
  import async_ram_pkg::*;

  logic clk;
  logic clr;
  int   checks;
  int   errors;

  ram_word_t m_mem [RAM_DEPTH];
  ram_word_t m_out;

  async_ram_if #(.DATA_W(RAM_DATA_W), .ADDR_W(RAM_ADDR_W)) bus ();

  async_ram #(
    .DATA_W (RAM_DATA_W),
    .ADDR_W (RAM_ADDR_W),
    .DEPTH  (RAM_DEPTH)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    for (int i = 0; i < RAM_DEPTH; i++) m_mem[i] = '0;
    m_out = '0;
  endtask

  // One clock edge with the given request; updates the model, returns at edge+1.
  task automatic cycle(input logic w, input logic [2:0] wa, input ram_word_t d,
                       input logic r, input logic [2:0] ra);
    bus.we      = w;
    bus.wr_addr = wa;
    bus.data_in = d;
    bus.re      = r;
    bus.rd_addr = ra;
    @(posedge clk);
    if (r) m_out = m_mem[ra];
    if (w) m_mem[wa] = d;
    #1;
    bus.we = 1'b0;
    bus.re = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    bus.we = 1'b0; bus.re = 1'b0;
    bus.wr_addr = '0; bus.rd_addr = '0; bus.data_in = '0;
    #50;
    model_clear();
    checks++;
    if (bus.data_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data_out: got %h expected 0000", bus.data_out);
    end
    clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, '0, '0, 1'b1, 3'(i));
      checks++;
      if (bus.data_out !== 16'h0000) begin
        errors++;
        $display("FAIL reset_read[%0d]: got %h expected 0000", i, bus.data_out);
      end
    end
  endtask

  task automatic test_fill();
    ram_word_t exp;
    for (int i = 0; i < 8; i++) cycle(1'b1, 3'(i), 16'((i + 3) % 16), 1'b0, '0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, '0, '0, 1'b1, 3'(i));
      exp = 16'((i + 3) % 16);
      checks++;
      if (bus.data_out !== exp || m_out !== exp) begin
        errors++;
        $display("FAIL fill_read[%0d]: got %h expected %h", i, bus.data_out, exp);
      end
    end
  endtask

  task automatic test_hold();
    cycle(1'b0, '0, '0, 1'b1, 3'd5);
    cycle(1'b1, 3'd5, 16'hBEEF, 1'b0, '0);
    checks++;
    if (bus.data_out !== 16'h0008) begin
      errors++;
      $display("FAIL hold: got %h expected 0008", bus.data_out);
    end
    cycle(1'b0, '0, '0, 1'b1, 3'd5);
    checks++;
    if (bus.data_out !== 16'hBEEF) begin
      errors++;
      $display("FAIL hold_reread: got %h expected beef", bus.data_out);
    end
  endtask

  task automatic test_collision();
    cycle(1'b1, 3'd2, 16'h1111, 1'b0, '0);
    cycle(1'b1, 3'd2, 16'h2222, 1'b1, 3'd2);
    checks++;
    if (bus.data_out !== 16'h1111) begin
      errors++;
      $display("FAIL collision_old: got %h expected 1111", bus.data_out);
    end
    cycle(1'b0, '0, '0, 1'b1, 3'd2);
    checks++;
    if (bus.data_out !== 16'h2222) begin
      errors++;
      $display("FAIL collision_new: got %h expected 2222", bus.data_out);
    end
  endtask

  task automatic test_we_protect();
    ram_word_t prior;
    prior = m_mem[4];
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd4, 16'hFFFF, 1'b0, '0);
    cycle(1'b0, '0, '0, 1'b1, 3'd4);
    checks++;
    if (bus.data_out !== prior) begin
      errors++;
      $display("FAIL we_protect: got %h expected %h", bus.data_out, prior);
    end
  endtask

  task automatic test_random();
    logic w, r;
    logic [2:0] wa, ra;
    ram_word_t d;
    for (int n = 0; n < 300; n++) begin
      w  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      wa = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      d  = 16'($urandom);
      cycle(w, wa, d, r, ra);
      checks++;
      if (bus.data_out !== m_out) begin
        errors++;
        $display("FAIL random[%0d]: got %h expected %h", n, bus.data_out, m_out);
      end
    end
  endtask

  task automatic test_async_clear();
    for (int i = 0; i < 8; i++) cycle(1'b1, 3'(i), 16'h8000 | 16'(i + 1), 1'b0, '0);
    cycle(1'b0, '0, '0, 1'b1, 3'd6);
    checks++;
    if (bus.data_out !== 16'h8007) begin
      errors++;
      $display("FAIL preclear_read: got %h expected 8007", bus.data_out);
    end
    // now at edge+1: assert clear well before the next edge
    clr = 1'b1;
    #2;
    model_clear();
    checks++;
    if (bus.data_out !== 16'h0000) begin
      errors++;
      $display("FAIL async_clear_out: got %h expected 0000", bus.data_out);
    end
    #3;
    clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, '0, '0, 1'b1, 3'(i));
      checks++;
      if (bus.data_out !== m_out || m_out !== 16'h0000) begin
        errors++;
        $display("FAIL async_clear_read[%0d]: got %h expected 0000", i, bus.data_out);
      end
    end
  endtask

  task automatic test_clear_on_edge();
    cycle(1'b1, 3'd1, 16'h5A5A, 1'b0, '0);
    cycle(1'b0, '0, '0, 1'b1, 3'd1);
    checks++;
    if (bus.data_out !== 16'h5A5A) begin
      errors++;
      $display("FAIL edge_pre: got %h expected 5a5a", bus.data_out);
    end
    // access presented together with clr across an edge must be discarded
    #8;
    bus.we = 1'b1; bus.wr_addr = 3'd1; bus.data_in = 16'hAAAA;
    bus.re = 1'b1; bus.rd_addr = 3'd1;
    clr = 1'b1;
    @(posedge clk);
    #4;
    clr = 1'b0;
    bus.we = 1'b0; bus.re = 1'b0;
    model_clear();
    cycle(1'b0, '0, '0, 1'b1, 3'd1);
    checks++;
    if (bus.data_out !== 16'h0000) begin
      errors++;
      $display("FAIL edge_discard: got %h expected 0000", bus.data_out);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr    = 1'b1;
    test_reset();
    test_fill();
    test_hold();
    test_collision();
    test_we_protect();
    test_random();
    test_async_clear();
    test_clear_on_edge();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_async_ram
